// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS writeback slice: widths, load-type
// encoding and the writeback FSM state type.
package mips_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LH  = 3'd1,
        LD_LW  = 3'd3,
        LD_LBU = 3'd4,
        LD_LHU = 3'd5
    } ld_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_MEM,
        ST_ERROR
    } wb_state_e;

    // Register 0 is hard-wired, so writes to it are swallowed.
    function automatic logic is_write_reg(input logic [REG_W-1:0] r);
        return r != '0;
    endfunction

endpackage

// File: rtl/mips_load_extract.sv
// Little-endian byte/halfword/word extraction with sign or zero extension.
module mips_load_extract
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [2:0]        ld_type,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[offset];
    // Halfword lane is chosen by the upper offset bit only.
    assign half_sel = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = word;
        case (ld_type)
            LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  result = {24'h0, byte_sel};
            LD_LH:   result = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  result = {16'h0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mips_writeback.sv
// Writeback stage: merges ALU results and a single outstanding load into
// one registered register-file write port, with load timeout detection.
module mips_writeback
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_issue,
    input  logic [REG_W-1:0]  ld_rt,
    input  logic [2:0]        ld_type,
    input  logic [1:0]        ld_offset,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              reg_write,
    output logic [REG_W-1:0]  reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              stall,
    output logic              pend_valid,
    output logic [REG_W-1:0]  pend_reg,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    wb_state_e         state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [2:0]        type_reg, type_next;
    logic [1:0]        offset_reg, offset_next;
    logic              cancel_reg, cancel_next;
    logic              buf_valid_reg, buf_valid_next;
    logic [REG_W-1:0]  buf_rd_reg, buf_rd_next;
    logic [DATA_W-1:0] buf_data_reg, buf_data_next;
    logic              pend_valid_next;
    logic [REG_W-1:0]  pend_reg_next;
    logic              timeout_next;
    logic              reg_write_next;
    logic [REG_W-1:0]  reg_waddr_next;
    logic [DATA_W-1:0] reg_wdata_next;
    logic [DATA_W-1:0] ld_data;
    logic              alu_accept;
    logic              ld_ret;

    mips_load_extract u_extract (
        .word    (mem_rdata),
        .ld_type (type_reg),
        .offset  (offset_reg),
        .result  (ld_data)
    );

    // A full buffer means upstream is holding its result, so alu_valid is ignored.
    assign alu_accept = alu_valid && !buf_valid_reg;
    assign ld_ret     = (state_reg == ST_WAIT_MEM) && mem_rvalid;

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        type_next       = type_reg;
        offset_next     = offset_reg;
        cancel_next     = cancel_reg;
        pend_valid_next = pend_valid;
        pend_reg_next   = pend_reg;
        timeout_next    = timeout_err;
        buf_valid_next  = buf_valid_reg;
        buf_rd_next     = buf_rd_reg;
        buf_data_next   = buf_data_reg;
        reg_write_next  = 1'b0;
        reg_waddr_next  = reg_waddr;
        reg_wdata_next  = reg_wdata;
        stall           = buf_valid_reg || (ld_issue && (state_reg != ST_IDLE));

        case (state_reg)
            ST_IDLE: begin
                if (ld_issue) begin
                    type_next       = ld_type;
                    offset_next     = ld_offset;
                    pend_valid_next = 1'b1;
                    pend_reg_next   = ld_rt;
                    count_next      = '0;
                    cancel_next     = 1'b0;
                    state_next      = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    pend_valid_next = 1'b0;
                    cancel_next     = 1'b0;
                    state_next      = ST_IDLE;
                end else begin
                    // A younger ALU write to the load's target makes the load stale.
                    if (alu_accept && is_write_reg(alu_rd) && (alu_rd == pend_reg))
                        cancel_next = 1'b1;
                    if (count_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        count_next      = CNT_W'(TIMEOUT_CYCLES);
                        state_next      = ST_ERROR;
                        timeout_next    = 1'b1;
                        pend_valid_next = 1'b0;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        // Write-port arbitration: load return, then buffered ALU, then live ALU.
        if (ld_ret) begin
            reg_write_next = !cancel_reg && is_write_reg(pend_reg);
            reg_waddr_next = pend_reg;
            reg_wdata_next = ld_data;
            if (alu_accept) begin
                buf_valid_next = 1'b1;
                buf_rd_next    = alu_rd;
                buf_data_next  = alu_data;
            end
        end else if (buf_valid_reg) begin
            reg_write_next = is_write_reg(buf_rd_reg);
            reg_waddr_next = buf_rd_reg;
            reg_wdata_next = buf_data_reg;
            buf_valid_next = 1'b0;
        end else if (alu_accept) begin
            reg_write_next = is_write_reg(alu_rd);
            reg_waddr_next = alu_rd;
            reg_wdata_next = alu_data;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            type_reg      <= '0;
            offset_reg    <= '0;
            cancel_reg    <= 1'b0;
            buf_valid_reg <= 1'b0;
            buf_rd_reg    <= '0;
            buf_data_reg  <= '0;
            pend_valid    <= 1'b0;
            pend_reg      <= '0;
            timeout_err   <= 1'b0;
            reg_write     <= 1'b0;
            reg_waddr     <= '0;
            reg_wdata     <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            type_reg      <= type_next;
            offset_reg    <= offset_next;
            cancel_reg    <= cancel_next;
            buf_valid_reg <= buf_valid_next;
            buf_rd_reg    <= buf_rd_next;
            buf_data_reg  <= buf_data_next;
            pend_valid    <= pend_valid_next;
            pend_reg      <= pend_reg_next;
            timeout_err   <= timeout_next;
            reg_write     <= reg_write_next;
            reg_waddr     <= reg_waddr_next;
            reg_wdata     <= reg_wdata_next;
        end
    end

endmodule

// File: doc/mips_writeback.md
MIPS_WRITEBACK -- requirements
Module: mips_writeback

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of cycles to wait for a load return.
REQ-002 SHALL have the port CLK, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have the port RESETN, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have the inputs alu_valid (1), alu_rd (5) and alu_data (32): the ALU result to be written.
REQ-005 SHALL have the inputs ld_issue (1), ld_rt (5), ld_type (3) and ld_offset (2): a load request issued to memory.
REQ-006 SHALL have the inputs mem_rvalid (1) and mem_rdata (32): the word returned by memory.
REQ-007 SHALL have the outputs reg_write (1), reg_waddr (5) and reg_wdata (32): the register-file write port.
REQ-008 SHALL have the outputs stall (1), pend_valid (1), pend_reg (5) and timeout_err (1).

Function
REQ-009 SHALL register reg_write, reg_waddr and reg_wdata, with a 1-cycle latency from an accepted result to reg_write=1.
REQ-010 SHALL consume a result with destination 0 without asserting reg_write.
REQ-011 SHALL implement an FSM with states IDLE, WAIT_MEM and ERROR.
REQ-012 In IDLE, ld_issue=1 SHALL capture ld_rt, ld_type and ld_offset, set pend_valid=1 and pend_reg=ld_rt, clear the timeout counter and move to WAIT_MEM.
REQ-013 In WAIT_MEM, mem_rvalid=1 SHALL write the extracted load data to pend_reg, clear pend_valid and return to IDLE.
REQ-014 mem_rvalid SHALL be ignored in IDLE and in ERROR.
REQ-015 In WAIT_MEM the counter SHALL increment every cycle without mem_rvalid; reaching TIMEOUT_CYCLES SHALL move to ERROR, set timeout_err=1 and clear pend_valid.
REQ-016 ERROR SHALL be left only by reset.
REQ-017 Only one load SHALL be outstanding: ld_issue in WAIT_MEM or ERROR SHALL not be accepted and SHALL assert stall combinationally in that cycle.
REQ-018 ld_issue and mem_rvalid in the same WAIT_MEM cycle SHALL complete the return only; the new issue is not accepted.
REQ-019 Extraction SHALL be little-endian: the lane for LB/LBU is ld_offset; the lane for LH/LHU is ld_offset[1], with ld_offset[0] ignored; LW ignores ld_offset.
REQ-020 LB and LH SHALL sign-extend, LBU and LHU SHALL zero-extend; reserved ld_type codes SHALL behave as LW.
REQ-021 A load return SHALL have priority over alu_valid in the same cycle; the ALU result SHALL be held in a 1-entry buffer and written on the next cycle.
REQ-022 While the buffer is full, stall SHALL be 1, and alu_valid SHALL be ignored because upstream holds its result.
REQ-023 An ALU write with alu_rd equal to pend_reg (non-zero) during WAIT_MEM SHALL mark the pending load cancelled.
REQ-024 A cancelled load's return SHALL be consumed with reg_write=0 and the FSM SHALL still return to IDLE.
REQ-025 ALU writes SHALL proceed in IDLE, WAIT_MEM and ERROR.

Reset
REQ-026 Asserting RESETN low SHALL asynchronously force: state IDLE, reg_write=0, reg_waddr=0, reg_wdata=0, pend_valid=0, pend_reg=0, timeout_err=0, buffer empty, counter 0 and the cancel flag cleared.
REQ-027 A reset during WAIT_MEM SHALL drop the pending load, and a mem_rvalid after reset release SHALL be ignored.
REQ-028 Outputs SHALL be valid from the first rising edge after RESETN is released high.

Structure
REQ-029 A shared package (mips_pkg) SHALL hold the ld_type encoding (LB=0, LH=1, LW=3, LBU=4, LHU=5), the register-address width (5) and the data width (32).
REQ-030 The package SHALL also hold the FSM state typedef.
REQ-031 Byte/halfword extraction SHALL be a combinational sub-module mips_load_extract (inputs: word, type, offset; output: 32-bit result).
REQ-032 The FSM, counter, buffer and output registers SHALL reside in mips_writeback.

Verification
REQ-033 ALU write: alu_valid, rd=5, data=0x12345678 -> the next cycle shows reg_write=1, waddr=5, wdata=0x12345678; with rd=0 -> reg_write stays 0.
REQ-034 Load extraction: LB at offset 3 on 0x80FF7F01 -> 0xFFFFFF80; LBU at offset 3 -> 0x00000080; LH at offset 2 -> 0xFFFF80FF; LW -> 0x80FF7F01.
REQ-035 Collision: mem_rvalid (rt=7) and alu_valid (rd=9) in the same cycle -> r7 is written at cycle+1 and r9 at cycle+2, with stall=1 for exactly one cycle.
REQ-036 Cancel: LW to r4, then an ALU write to r4 before the return -> only the ALU value reaches r4, and the FSM is in IDLE after the return.
REQ-037 Timeout: with TIMEOUT_CYCLES=4 and no return -> timeout_err=1 after 4 cycles; a second ld_issue -> stall=1; reset -> timeout_err=0 and state IDLE.
REQ-038 Reset mid-load: RESETN low during WAIT_MEM and a later mem_rvalid -> no reg_write and pend_valid=0.
